// File: rtl/fwd_stall_unit_pkg.sv
// Shared types and defaults for the forwarding / hazard-stall unit.
// Contents: default parameter values, register index type, stall-cause
// encoding and a helper that sizes the forward-select field.
package fwd_stall_unit_pkg;

  localparam int NUM_SRC_D  = 2;
  localparam int NUM_FWD_D  = 2;
  localparam int NUM_REGS_D = 32;
  localparam int MAX_PEND_D = 4;
  localparam int TIMEOUT_D  = 255;
  localparam int CNT_W_D    = 16;
  localparam int REG_W      = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Stall cause, ordered so RUN is the idle/reset encoding.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    SB_WAIT  = 2'd2,
    FULL     = 2'd3
  } stall_cause_t;

  // Forward select width: value 0 means regfile, k means stage k-1.
  function automatic int sel_w(input int num_fwd);
    return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
  endfunction

  typedef logic [sel_w(NUM_FWD_D)-1:0] fwd_sel_t;

endpackage

// File: rtl/fwd_stall_unit_if.sv
// Bundle between the EX-side pipeline and the forwarding / stall unit.
// slave  : the unit (consumes EX/forward/issue/completion info, drives results)
// master : the pipeline (drives the i_* signals, observes the o_* signals)
// i_* : EX operands, downstream stage info, long-latency issue/completion
// o_* : forward selects, stall, pending-full, counters, sticky errors and
//       debug views of the stall-cause state, pending count and busy vector
interface fwd_stall_unit_if
  import fwd_stall_unit_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_D,
  parameter int NUM_FWD  = NUM_FWD_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int CNT_W    = CNT_W_D,
  parameter int PEND_W   = $clog2(MAX_PEND_D + 1)
);
  localparam int SELW = sel_w(NUM_FWD);

  logic                             i_ex_valid;
  logic [NUM_SRC-1:0][REG_W-1:0]    i_ex_src;
  logic [NUM_SRC-1:0]               i_ex_src_used;
  logic [NUM_FWD-1:0]               i_fwd_valid;
  logic [NUM_FWD-1:0]               i_fwd_wr;
  logic [NUM_FWD-1:0][REG_W-1:0]    i_fwd_dest;
  logic [NUM_FWD-1:0]               i_fwd_rdy;
  logic                             i_issue_long;
  logic [REG_W-1:0]                 i_issue_dest;
  logic                             i_cpl_long;
  logic [REG_W-1:0]                 i_cpl_dest;

  logic [NUM_SRC-1:0][SELW-1:0]     o_fwd_sel;
  logic                             o_stall;
  logic                             o_pend_full;
  logic [CNT_W-1:0]                 o_stall_cycles;
  logic                             o_sb_error;
  logic                             o_sb_timeout;
  logic [1:0]                       o_dbg_state;
  logic [PEND_W-1:0]                o_dbg_pend_cnt;
  logic [NUM_REGS-1:0]              o_dbg_busy;

  modport slave (
    input  i_ex_valid, i_ex_src, i_ex_src_used, i_fwd_valid, i_fwd_wr,
           i_fwd_dest, i_fwd_rdy, i_issue_long, i_issue_dest, i_cpl_long,
           i_cpl_dest,
    output o_fwd_sel, o_stall, o_pend_full, o_stall_cycles, o_sb_error,
           o_sb_timeout, o_dbg_state, o_dbg_pend_cnt, o_dbg_busy
  );

  modport master (
    output i_ex_valid, i_ex_src, i_ex_src_used, i_fwd_valid, i_fwd_wr,
           i_fwd_dest, i_fwd_rdy, i_issue_long, i_issue_dest, i_cpl_long,
           i_cpl_dest,
    input  o_fwd_sel, o_stall, o_pend_full, o_stall_cycles, o_sb_error,
           o_sb_timeout, o_dbg_state, o_dbg_pend_cnt, o_dbg_busy
  );

endinterface

// File: rtl/fwd_stall_unit_reg_scoreboard.sv
// Register scoreboard for long-latency writes.
// Ports: clk/rst; i_set/i_set_dest mark a register busy; i_clr/i_clr_dest
// release one; i_lookup/o_lookup_busy and i_waw_dest/o_waw_busy are busy
// lookups; o_busy, o_pend_cnt, o_pend_full and sticky o_sb_error report state.
module fwd_stall_unit_reg_scoreboard
  import fwd_stall_unit_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int MAX_PEND = MAX_PEND_D,
  parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_set,
  input  logic [REG_W-1:0]              i_set_dest,
  input  logic                          i_clr,
  input  logic [REG_W-1:0]              i_clr_dest,
  input  logic [NUM_SRC-1:0][REG_W-1:0] i_lookup,
  output logic [NUM_SRC-1:0]            o_lookup_busy,
  input  logic [REG_W-1:0]              i_waw_dest,
  output logic                          o_waw_busy,
  output logic [NUM_REGS-1:0]           o_busy,
  output logic [PEND_W-1:0]             o_pend_cnt,
  output logic                          o_pend_full,
  output logic                          o_sb_error
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [PEND_W-1:0]   r_pend_cnt;
  logic                r_sb_error;
  logic                w_clr_valid;

  // A completion only counts if the register was actually outstanding.
  assign w_clr_valid = i_clr & r_busy[i_clr_dest];

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr) w_busy_next[i_clr_dest] = 1'b0;
    if (i_set) w_busy_next[i_set_dest] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
      r_sb_error <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      case ({i_set, w_clr_valid})
        2'b10:   r_pend_cnt <= r_pend_cnt + 1'b1;
        2'b01:   r_pend_cnt <= r_pend_cnt - 1'b1;
        default: r_pend_cnt <= r_pend_cnt;
      endcase
      if (i_clr && !r_busy[i_clr_dest]) r_sb_error <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
      assign o_lookup_busy[gi] = r_busy[i_lookup[gi]];
    end
  endgenerate

  assign o_waw_busy  = r_busy[i_waw_dest];
  assign o_busy      = r_busy;
  assign o_pend_cnt  = r_pend_cnt;
  assign o_pend_full = (r_pend_cnt == PEND_W'(MAX_PEND));
  assign o_sb_error  = r_sb_error;

endmodule

// File: rtl/fwd_stall_unit.sv
// Operand-forwarding and hazard-stall unit beside EX.
// Ports: clk, rst (async, active-high) and bus (fwd_stall_unit_if.slave)
// carrying EX operands, downstream stage info, long-latency issue/completion
// and returning forward selects, stall, pend_full, stall counter, sticky
// scoreboard error/timeout and debug state.
module fwd_stall_unit
  import fwd_stall_unit_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_D,
  parameter int NUM_FWD  = NUM_FWD_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int MAX_PEND = MAX_PEND_D,
  parameter int TIMEOUT  = TIMEOUT_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic          clk,
  input  logic          rst,
  fwd_stall_unit_if.slave bus
);

  localparam int SELW   = sel_w(NUM_FWD);
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 2);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_LOAD_USE = LOAD_USE;
  localparam logic [1:0] ST_SB_WAIT  = SB_WAIT;
  localparam logic [1:0] ST_FULL     = FULL;

  logic [NUM_SRC-1:0][SELW-1:0] w_sel;
  logic [NUM_SRC-1:0]           w_lu_s;
  logic [NUM_SRC-1:0]           w_sbw_s;
  logic [NUM_SRC-1:0]           w_lookup_busy;
  logic                         w_waw_busy;
  logic                         w_pend_full;
  logic [PEND_W-1:0]            w_pend_cnt;
  logic                         w_sb_error;
  logic [NUM_REGS-1:0]          w_busy;
  logic                         w_load_use;
  logic                         w_sb_wait;
  logic                         w_waw;
  logic                         w_full;
  logic                         w_stall;
  logic                         w_set;
  logic [1:0]                   w_state_next;

  logic [1:0]                   r_state;
  logic [WAIT_W-1:0]            r_wait_cnt;
  logic                         r_sb_timeout;
  logic [CNT_W-1:0]             r_stall_cnt;

  // Per-source forward select: lowest (youngest) matching stage wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic            w_src_en;
      logic [SELW-1:0] w_sel_g;
      logic            w_win_rdy;

      assign w_src_en = bus.i_ex_src_used[gi] & (bus.i_ex_src[gi] != '0);

      // Scan oldest to youngest so the youngest match overwrites.
      always_comb begin
        w_sel_g   = '0;
        w_win_rdy = 1'b1;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (w_src_en && bus.i_fwd_valid[k] && bus.i_fwd_wr[k] &&
              (bus.i_fwd_dest[k] == bus.i_ex_src[gi])) begin
            w_sel_g   = SELW'(k + 1);
            w_win_rdy = bus.i_fwd_rdy[k];
          end
        end
      end

      assign w_sel[gi]   = w_sel_g;
      assign w_lu_s[gi]  = (w_sel_g != '0) & ~w_win_rdy;
      // Write-through regfile: a same-cycle completion satisfies the read.
      assign w_sbw_s[gi] = w_src_en & w_lookup_busy[gi] &
                           ~(bus.i_cpl_long & (bus.i_cpl_dest == bus.i_ex_src[gi]));
    end
  endgenerate

  assign w_load_use = bus.i_ex_valid & (|w_lu_s);
  assign w_sb_wait  = bus.i_ex_valid & (|w_sbw_s);
  assign w_waw      = bus.i_ex_valid & bus.i_issue_long & w_waw_busy &
                      ~(bus.i_cpl_long & (bus.i_cpl_dest == bus.i_issue_dest));
  assign w_full     = bus.i_ex_valid & bus.i_issue_long & w_pend_full & ~bus.i_cpl_long;
  assign w_stall    = w_load_use | w_sb_wait | w_waw | w_full;

  assign w_set = bus.i_ex_valid & bus.i_issue_long & ~w_stall & (bus.i_issue_dest != '0);

  fwd_stall_unit_reg_scoreboard #(
    .NUM_SRC  (NUM_SRC),
    .NUM_REGS (NUM_REGS),
    .MAX_PEND (MAX_PEND),
    .PEND_W   (PEND_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .i_set         (w_set),
    .i_set_dest    (bus.i_issue_dest),
    .i_clr         (bus.i_cpl_long),
    .i_clr_dest    (bus.i_cpl_dest),
    .i_lookup      (bus.i_ex_src),
    .o_lookup_busy (w_lookup_busy),
    .i_waw_dest    (bus.i_issue_dest),
    .o_waw_busy    (w_waw_busy),
    .o_busy        (w_busy),
    .o_pend_cnt    (w_pend_cnt),
    .o_pend_full   (w_pend_full),
    .o_sb_error    (w_sb_error)
  );

  // Highest-priority current cause; the register is only a perf/debug view.
  always_comb begin
    w_state_next = ST_RUN;
    if (w_load_use)              w_state_next = ST_LOAD_USE;
    else if (w_sb_wait || w_waw) w_state_next = ST_SB_WAIT;
    else if (w_full)             w_state_next = ST_FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= '0;
      r_sb_timeout <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      // Saturate one past TIMEOUT so the counter cannot wrap back below it.
      if (r_state == ST_SB_WAIT) begin
        if (r_wait_cnt <= WAIT_W'(TIMEOUT)) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_wait_cnt > WAIT_W'(TIMEOUT)) r_sb_timeout <= 1'b1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.o_fwd_sel      = w_sel;
  assign bus.o_stall        = w_stall;
  assign bus.o_pend_full    = w_pend_full;
  assign bus.o_stall_cycles = r_stall_cnt;
  assign bus.o_sb_error     = w_sb_error;
  assign bus.o_sb_timeout   = r_sb_timeout;
  assign bus.o_dbg_state    = r_state;
  assign bus.o_dbg_pend_cnt = w_pend_cnt;
  assign bus.o_dbg_busy     = w_busy;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Testbench for fwd_stall_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the forwarding/stall rules.
module tb_fwd_stall_unit;

  localparam int NS   = 2;
  localparam int NF   = 2;
  localparam int MAXP = 4;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_stall_unit_if #(.NUM_SRC(NS), .NUM_FWD(NF), .NUM_REGS(32), .CNT_W(16), .PEND_W(3)) bus ();

  fwd_stall_unit #(
    .NUM_SRC(NS), .NUM_FWD(NF), .NUM_REGS(32), .MAX_PEND(MAXP), .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy [32];
  int m_pend, m_state, m_scnt, m_wait;
  bit m_err, m_tmo;
  // Model expectations for the current inputs
  int e_sel [NS];
  bit e_stall;
  int e_next;

  task automatic idle_inputs();
    bus.i_ex_valid    = 1'b0;
    bus.i_ex_src      = '0;
    bus.i_ex_src_used = '0;
    bus.i_fwd_valid   = '0;
    bus.i_fwd_wr      = '0;
    bus.i_fwd_dest    = '0;
    bus.i_fwd_rdy     = '0;
    bus.i_issue_long  = 1'b0;
    bus.i_issue_dest  = '0;
    bus.i_cpl_long    = 1'b0;
    bus.i_cpl_dest    = '0;
  endtask

  function automatic void model_reset();
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_pend = 0; m_state = 0; m_scnt = 0; m_wait = 0; m_err = 0; m_tmo = 0;
  endfunction

  // Expected selects, stall and next cause from the hazard rules.
  function automatic void model_eval();
    bit lu = 0, sbw = 0, waw = 0, full = 0;
    int src;
    for (int s = 0; s < NS; s++) begin
      e_sel[s] = 0;
      src = int'(bus.i_ex_src[s]);
      if (bus.i_ex_src_used[s] && src != 0) begin
        for (int k = 0; k < NF; k++)
          if (e_sel[s] == 0 && bus.i_fwd_valid[k] && bus.i_fwd_wr[k] && int'(bus.i_fwd_dest[k]) == src)
            e_sel[s] = k + 1;
        if (e_sel[s] != 0 && !bus.i_fwd_rdy[e_sel[s]-1]) lu = 1;
        if (m_busy[src] && !(bus.i_cpl_long && int'(bus.i_cpl_dest) == src)) sbw = 1;
      end
    end
    if (bus.i_issue_long && m_busy[bus.i_issue_dest] &&
        !(bus.i_cpl_long && bus.i_cpl_dest == bus.i_issue_dest)) waw = 1;
    if (bus.i_issue_long && m_pend == MAXP && !bus.i_cpl_long) full = 1;
    if (!bus.i_ex_valid) begin lu = 0; sbw = 0; waw = 0; full = 0; end
    e_stall = lu | sbw | waw | full;
    e_next  = lu ? 1 : (sbw | waw) ? 2 : full ? 3 : 0;
  endfunction

  // Advance one clock and update the model with the applied inputs.
  task automatic tick();
    bit set, clr_ok;
    model_eval();
    set    = bus.i_issue_long && bus.i_ex_valid && !e_stall && bus.i_issue_dest != 0;
    clr_ok = bus.i_cpl_long && m_busy[bus.i_cpl_dest];
    if (bus.i_cpl_long && !m_busy[bus.i_cpl_dest]) m_err = 1;
    if (m_wait > TMO) m_tmo = 1;
    m_wait  = (m_state == 2) ? m_wait + 1 : 0;
    m_state = e_next;
    if (e_stall && m_scnt < 65535) m_scnt++;
    if (bus.i_cpl_long) m_busy[bus.i_cpl_dest] = 1'b0;
    if (set) m_busy[bus.i_issue_dest] = 1'b1;
    m_pend = m_pend + int'(set) - int'(clr_ok);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic reader(input int s, input int r);
    bus.i_ex_valid       = 1'b1;
    bus.i_ex_src[s]      = 5'(r);
    bus.i_ex_src_used[s] = 1'b1;
  endtask

  task automatic issue(input int r);
    bus.i_ex_valid   = 1'b1;
    bus.i_issue_long = 1'b1;
    bus.i_issue_dest = 5'(r);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", bus.o_stall); end
    checks++; if (bus.o_fwd_sel !== '0) begin errors++; $display("FAIL rst_sel: got %0h want 0", bus.o_fwd_sel); end
    checks++; if (bus.o_stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_scnt: got %0d want 0", bus.o_stall_cycles); end
    checks++; if ({bus.o_sb_error, bus.o_sb_timeout, bus.o_pend_full} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %03b want 000", {bus.o_sb_error, bus.o_sb_timeout, bus.o_pend_full}); end
    checks++; if (bus.o_dbg_state !== 2'd0 || bus.o_dbg_pend_cnt !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d/%0d want 0/0", bus.o_dbg_state, bus.o_dbg_pend_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_forward_youngest();
    do_reset();
    reader(0, 5);
    bus.i_fwd_valid = 2'b11; bus.i_fwd_wr = 2'b11; bus.i_fwd_rdy = 2'b11;
    bus.i_fwd_dest[0] = 5'd5; bus.i_fwd_dest[1] = 5'd5;
    #1;
    checks++; if (bus.o_fwd_sel[0] !== 2'd1) begin errors++; $display("FAIL fwd_young_sel: got %0d want 1", bus.o_fwd_sel[0]); end
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL fwd_young_stall: got %0b want 0", bus.o_stall); end
    $display("fwd: src=x5 sel=%0d stall=%0b", bus.o_fwd_sel[0], bus.o_stall);
    bus.i_fwd_valid = 2'b10;
    #1;
    checks++; if (bus.o_fwd_sel[0] !== 2'd2) begin errors++; $display("FAIL fwd_old_sel: got %0d want 2", bus.o_fwd_sel[0]); end
    $display("fwd: src=x5 stage1-only sel=%0d", bus.o_fwd_sel[0]);
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    reader(0, 7);
    bus.i_fwd_valid = 2'b01; bus.i_fwd_wr = 2'b01; bus.i_fwd_rdy = 2'b00;
    bus.i_fwd_dest[0] = 5'd7;
    #1;
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", bus.o_stall); end
    tick();
    checks++; if (bus.o_dbg_state !== 2'd1) begin errors++; $display("FAIL lu_state: got %0d want 1", bus.o_dbg_state); end
    $display("load-use: stall=%0b state=%0d", bus.o_stall, bus.o_dbg_state);
    bus.i_fwd_valid = 2'b10; bus.i_fwd_wr = 2'b10; bus.i_fwd_rdy = 2'b10;
    bus.i_fwd_dest[0] = 5'd0; bus.i_fwd_dest[1] = 5'd7;
    #1;
    checks++; if (bus.o_fwd_sel[0] !== 2'd2 || bus.o_stall !== 1'b0) begin errors++; $display("FAIL lu_drop: got sel=%0d stall=%0b want sel=2 stall=0", bus.o_fwd_sel[0], bus.o_stall); end
    tick();
  endtask

  task automatic test_sb_wait();
    do_reset();
    issue(9);
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL sbw_issue: got %0b want 0", bus.o_stall); end
    tick();
    idle_inputs();
    reader(1, 9);
    for (int c = 2; c <= 5; c++) begin
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL sbw_stall_c%0d: got %0b want 1", c, bus.o_stall); end
      $display("sb-wait cycle %0d: stall=%0b state=%0d", c, bus.o_stall, bus.o_dbg_state);
      tick();
    end
    checks++; if (bus.o_dbg_state !== 2'd2) begin errors++; $display("FAIL sbw_state: got %0d want 2", bus.o_dbg_state); end
    bus.i_cpl_long = 1'b1; bus.i_cpl_dest = 5'd9;
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL sbw_release: got %0b want 0", bus.o_stall); end
    tick();
    checks++; if (bus.o_dbg_pend_cnt !== 3'd0) begin errors++; $display("FAIL sbw_pend: got %0d want 0", bus.o_dbg_pend_cnt); end
  endtask

  task automatic test_pend_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin issue(r); tick(); end
    checks++; if (bus.o_pend_full !== 1'b1 || bus.o_dbg_pend_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt: got full=%0b cnt=%0d want 1/4", bus.o_pend_full, bus.o_dbg_pend_cnt); end
    issue(5);
    #1;
    checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b want 1", bus.o_stall); end
    bus.i_cpl_long = 1'b1; bus.i_cpl_dest = 5'd2;
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL full_release: got %0b want 0", bus.o_stall); end
    tick();
    checks++; if (bus.o_dbg_pend_cnt !== 3'd4 || bus.o_dbg_busy[5] !== 1'b1 || bus.o_dbg_busy[2] !== 1'b0) begin errors++; $display("FAIL full_after: got cnt=%0d b5=%0b b2=%0b want 4/1/0", bus.o_dbg_pend_cnt, bus.o_dbg_busy[5], bus.o_dbg_busy[2]); end
    $display("pend-full: cnt=%0d busy=%08h", bus.o_dbg_pend_cnt, bus.o_dbg_busy);
  endtask

  task automatic test_sb_error();
    do_reset();
    bus.i_cpl_long = 1'b1; bus.i_cpl_dest = 5'd12;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_sb_error !== 1'b1 || bus.o_dbg_pend_cnt !== 3'd0) begin errors++; $display("FAIL sberr: got err=%0b cnt=%0d want 1/0", bus.o_sb_error, bus.o_dbg_pend_cnt); end
    reader(0, 0); reader(1, 0);
    bus.i_fwd_valid = 2'b11; bus.i_fwd_wr = 2'b11; bus.i_fwd_rdy = 2'b00;
    #1;
    checks++; if (bus.o_fwd_sel !== '0 || bus.o_stall !== 1'b0) begin errors++; $display("FAIL x0_sel: got sel=%0h stall=%0b want 0/0", bus.o_fwd_sel, bus.o_stall); end
    $display("sb-error: err=%0b x0 sel=%0h", bus.o_sb_error, bus.o_fwd_sel);
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    issue(9);
    tick();
    idle_inputs();
    reader(0, 9);
    for (int c = 0; c < 300; c++) tick();
    #1;
    checks++; if (bus.o_sb_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b want 1", bus.o_sb_timeout); end
    checks++; if (bus.o_stall_cycles !== 16'd300) begin errors++; $display("FAIL tmo_scnt: got %0d want 300", bus.o_stall_cycles); end
    $display("timeout: sb_timeout=%0b stall_cycles=%0d", bus.o_sb_timeout, bus.o_stall_cycles);
    rst = 1'b1;
    #1;
    checks++; if (bus.o_sb_timeout !== 1'b0 || bus.o_stall_cycles !== 16'd0 || bus.o_stall !== 1'b0) begin errors++; $display("FAIL midrst_out: got tmo=%0b scnt=%0d stall=%0b want 0/0/0", bus.o_sb_timeout, bus.o_stall_cycles, bus.o_stall); end
    checks++; if (bus.o_dbg_busy !== '0 || bus.o_dbg_pend_cnt !== 3'd0 || bus.o_dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got busy=%08h cnt=%0d st=%0d want 0", bus.o_dbg_busy, bus.o_dbg_pend_cnt, bus.o_dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_inputs();
  endtask

  task automatic test_random();
    int busy_list [$];
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bus.i_ex_valid = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) begin
        bus.i_ex_src[s]      = 5'($urandom_range(0, 7));
        bus.i_ex_src_used[s] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < NF; k++) begin
        bus.i_fwd_valid[k] = 1'($urandom_range(0, 1));
        bus.i_fwd_wr[k]    = 1'($urandom_range(0, 1));
        bus.i_fwd_dest[k]  = 5'($urandom_range(0, 7));
        bus.i_fwd_rdy[k]   = ($urandom_range(0, 3) != 0);
      end
      bus.i_issue_long = ($urandom_range(0, 3) == 0);
      bus.i_issue_dest = 5'($urandom_range(0, 7));
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
      bus.i_cpl_long = 1'b0;
      bus.i_cpl_dest = '0;
      if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.i_cpl_long = 1'b1;
        bus.i_cpl_dest = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      end
      #1;
      model_eval();
      for (int s = 0; s < NS; s++) begin
        checks++; if (int'(bus.o_fwd_sel[s]) != e_sel[s]) begin errors++; $display("FAIL rnd_sel%0d t=%0d: got %0d want %0d", s, t, bus.o_fwd_sel[s], e_sel[s]); end
      end
      checks++; if (bus.o_stall !== e_stall) begin errors++; $display("FAIL rnd_stall t=%0d: got %0b want %0b", t, bus.o_stall, e_stall); end
      checks++; if (int'(bus.o_dbg_pend_cnt) != m_pend || bus.o_pend_full !== (m_pend == MAXP)) begin errors++; $display("FAIL rnd_pend t=%0d: got %0d/%0b want %0d", t, bus.o_dbg_pend_cnt, bus.o_pend_full, m_pend); end
      checks++; if (int'(bus.o_stall_cycles) != m_scnt || int'(bus.o_dbg_state) != m_state) begin errors++; $display("FAIL rnd_regs t=%0d: got scnt=%0d st=%0d want %0d/%0d", t, bus.o_stall_cycles, bus.o_dbg_state, m_scnt, m_state); end
      checks++; if (bus.o_sb_error !== m_err || bus.o_sb_timeout !== m_tmo) begin errors++; $display("FAIL rnd_sticky t=%0d: got %0b/%0b want %0b/%0b", t, bus.o_sb_error, bus.o_sb_timeout, m_err, m_tmo); end
      $display("txn %0d: v=%0b src=%0d/%0d sel=%0d/%0d stall=%0b pend=%0d", t, bus.i_ex_valid, bus.i_ex_src[0], bus.i_ex_src[1], bus.o_fwd_sel[0], bus.o_fwd_sel[1], bus.o_stall, bus.o_dbg_pend_cnt);
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_forward_youngest();
    test_load_use();
    test_sb_wait();
    test_pend_full();
    test_sb_error();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
